// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared fetch constants, defaults and FSM encoding
package instruction_fetch_stage_pkg;
  localparam int INSTR_W = 32;
  localparam int IMM_W = 16;
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  typedef enum logic {REQ = 1'b0, HOLD = 1'b1} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// if_id_register: IF/ID pipeline register (valid, instr, pc_plus4); ports clk, rst, load, clear, d_* in, q outs; rst > clear > load
module if_id_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [INSTR_W-1:0] d_pc_plus4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc_plus4
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc_plus4 <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc_plus4 <= d_pc_plus4;
    end
  end
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC + req/ready imem fetch into IF/ID with stall skid, redirect and flush; ports clk/reset, imem_* handshake, stall/flush/redirect controls, if_id_* and imm16 outputs
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_pc_plus4,
  output logic [IMM_W-1:0]   imm16
);
  fetch_state_t state, state_n;
  logic [INSTR_W-1:0] pc, pc_n, skid, skid_n, pc_plus4;
  logic load, clear;
  assign pc_plus4 = pc + 32'd4;
  assign imem_req = (state == REQ) && !reset;
  assign imem_addr = pc;
  assign imm16 = if_id_instr[IMM_W-1:0];
  always_comb begin
    state_n = state;
    pc_n = pc;
    skid_n = skid;
    load = 1'b0;
    clear = 1'b0;
    if (redirect) begin
      pc_n = {redirect_pc[31:2], 2'b00};
      skid_n = NOP_INSTR;
      clear = 1'b1;
      state_n = REQ;
    end else if (flush) begin
      // a flushed HOLD drops the skid word and refetches the same PC
      clear = 1'b1;
      skid_n = state == HOLD ? NOP_INSTR : skid;
      state_n = REQ;
    end else if (state == HOLD) begin
      load = !stall;
      pc_n = stall ? pc : pc_plus4;
      state_n = stall ? HOLD : REQ;
    end else if (imem_ready) begin
      // a stalled accept parks the word in the skid so the bus is not re-read
      load = !stall;
      pc_n = stall ? pc : pc_plus4;
      skid_n = stall ? imem_data : skid;
      state_n = stall ? HOLD : REQ;
    end else begin
      clear = !stall;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc <= RESET_PC;
      skid <= NOP_INSTR;
    end else begin
      state <= state_n;
      pc <= pc_n;
      skid <= skid_n;
    end
  end
  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk       (clk),
    .rst       (reset),
    .load      (load),
    .clear     (clear),
    .d_instr   (state == HOLD ? skid : imem_data),
    .d_pc_plus4(pc_plus4),
    .valid     (if_id_valid),
    .instr     (if_id_instr),
    .pc_plus4  (if_id_pc_plus4)
  );
endmodule
